// File: rtl/manchester_forward_encoder.sv
// Re-encodes forwarded decoded bits as a Manchester stream (b -> ~b then b), via a small bit FIFO.
// Optional FWD_OVERFLOW_STICKY_EN: overflow latches until reset or forward_en sampled low.
module manchester_forward_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PW_WIDTH   = 6,
  parameter int MIN_HALF   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_data,
  input  logic                          in_clk,
  input  logic [PW_WIDTH-1:0]           in_pulsewidth,
  input  logic                          forward_en,
  input  logic                          swap_forward_bit,
  output logic                          out,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PW_WIDTH-1:0] MIN_N   = PW_WIDTH'(MIN_HALF);
  localparam logic [PW_WIDTH-1:0] CNT_ONE = PW_WIDTH'(1);
  localparam logic [LW-1:0]       FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]       LVL_ONE  = LW'(1);
  localparam logic [AW-1:0]       PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [PW_WIDTH-1:0]  r_cnt;
  logic [PW_WIDTH-1:0]  r_n;
  logic                 r_bit;
  logic                 r_out;
  logic                 r_overflow;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_push_req;
  logic                 w_full;
  logic                 w_head;
  logic                 w_wr_bit;
  logic [PW_WIDTH-1:0]  w_n;

  assign w_n        = (in_pulsewidth < MIN_N) ? MIN_N : in_pulsewidth;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_wr_bit   = in_data ^ swap_forward_bit;
  assign w_full     = (r_level == FULL_LVL);
  assign w_push_req = in_clk & forward_en;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_mem[gi] <= w_wr_bit;
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_state_next = FIRST_HALF;
        end
      end
      FIRST_HALF: begin
        if (r_cnt == '0) w_state_next = SECOND_HALF;
      end
      SECOND_HALF: begin
        if (r_cnt == '0) begin
          if (r_level != '0) begin
            w_pop        = 1'b1;
            w_state_next = FIRST_HALF;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_n        <= MIN_N;
      r_bit      <= 1'b0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Half length is frozen at pop time so mid-bit width changes wait for the next bit.
      if (w_pop) begin
        r_bit    <= w_head;
        r_out    <= ~w_head;
        r_n      <= w_n;
        r_cnt    <= w_n - CNT_ONE;
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else if (r_state == FIRST_HALF && r_cnt == '0) begin
        r_out <= r_bit;
        r_cnt <= r_n - CNT_ONE;
      end else if (r_state == SECOND_HALF && r_cnt == '0) begin
        r_out <= 1'b0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt - CNT_ONE;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase

`ifdef FWD_OVERFLOW_STICKY_EN
      if (!forward_en)  r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
`else
      r_overflow <= w_drop;
`endif
    end
  end

  assign out        = r_out;
  assign overflow   = r_overflow;
  assign fifo_level = r_level;
  assign busy       = (r_state != IDLE) || (r_level != '0);

endmodule

// File: tb/tb_manchester_forward_encoder.sv
// Bench for manchester_forward_encoder: directed vector table, corner sequences, and random
// traffic checked every cycle against a waveform-queue reference model.
module tb_manchester_forward_encoder;

  localparam int DEPTH = 4;
  localparam int PW    = 6;
  localparam int MINH  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_data = 1'b0;
  logic          in_clk = 1'b0;
  logic [PW-1:0] in_pulsewidth = '0;
  logic          forward_en = 1'b0;
  logic          swap_forward_bit = 1'b0;
  logic          out;
  logic          busy;
  logic          overflow;
  logic [2:0]    fifo_level;

  manchester_forward_encoder #(
    .FIFO_DEPTH(DEPTH),
    .PW_WIDTH(PW),
    .MIN_HALF(MINH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_clk(in_clk),
    .in_pulsewidth(in_pulsewidth),
    .forward_en(forward_en),
    .swap_forward_bit(swap_forward_bit),
    .out(out),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued bits, plus the literal per-cycle line levels still to be shown.
  bit q_fifo[$];
  bit q_wave[$];
  bit m_ov = 1'b0;

  typedef struct {
    logic          d;
    logic          s;
    logic          sw;
    logic [PW-1:0] pw;
    logic          eo;
    logic          eb;
    logic [2:0]    el;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(logic d, logic s, logic sw, int pw, logic eo, logic eb, int el);
    vec_t v;
    v.d = d; v.s = s; v.sw = sw; v.pw = PW'(pw); v.eo = eo; v.eb = eb; v.el = 3'(el);
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_fifo.delete();
    q_wave.delete();
    m_ov = 1'b0;
  endtask

  task automatic model_step();
    bit b;
    bit drop;
    int n;
    if (q_wave.size() > 0) void'(q_wave.pop_front());
    if (q_wave.size() == 0 && q_fifo.size() > 0) begin
      b = q_fifo.pop_front();
      n = (int'(in_pulsewidth) < MINH) ? MINH : int'(in_pulsewidth);
      for (int i = 0; i < n; i++) q_wave.push_back(!b);
      for (int i = 0; i < n; i++) q_wave.push_back(b);
    end
    drop = 1'b0;
    if (in_clk && forward_en) begin
      if (q_fifo.size() < DEPTH) begin
        q_fifo.push_back(in_data ^ swap_forward_bit);
        $display("enq bit=%0d level=%0d t=%0t", in_data ^ swap_forward_bit, q_fifo.size(), $time);
      end else begin
        drop = 1'b1;
        $display("drop bit=%0d t=%0t", in_data ^ swap_forward_bit, $time);
      end
    end
`ifdef FWD_OVERFLOW_STICKY_EN
    if (!forward_en) m_ov = 1'b0;
    else if (drop)   m_ov = 1'b1;
`else
    m_ov = drop;
`endif
  endtask

  task automatic cycle();
    logic m_out;
    @(posedge clk);
    model_step();
    @(negedge clk);
    m_out = (q_wave.size() > 0) ? q_wave[0] : 1'b0;
    chk("out", 8'(out), 8'(m_out));
    chk("busy", 8'(busy), 8'((q_wave.size() > 0) || (q_fifo.size() > 0)));
    chk("fifo_level", 8'(fifo_level), 8'(q_fifo.size()));
    chk("overflow", 8'(overflow), 8'(m_ov));
  endtask

  task automatic drive(input logic d, input logic s, input int pw, input logic en, input logic sw);
    in_data = d; in_clk = s; in_pulsewidth = PW'(pw); forward_en = en; swap_forward_bit = sw;
  endtask

  task automatic idle(input int n);
    in_clk = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int max_lvl;

    tv[0] = mk(1, 1, 0, 4, 0, 1, 1);
    tv[1] = mk(0, 0, 0, 4, 0, 1, 0);
    for (int i = 2; i <= 4; i++)  tv[i] = mk(0, 0, 0, 4, 0, 1, 0);
    for (int i = 5; i <= 8; i++)  tv[i] = mk(0, 0, 0, 4, 1, 1, 0);
    tv[9]  = mk(0, 0, 0, 4, 0, 0, 0);
    tv[10] = mk(1, 1, 1, 3, 0, 1, 1);
    for (int i = 11; i <= 13; i++) tv[i] = mk(0, 0, 0, 3, 1, 1, 0);
    for (int i = 14; i <= 16; i++) tv[i] = mk(0, 0, 0, 3, 0, 1, 0);
    tv[17] = mk(0, 0, 0, 3, 0, 0, 0);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 8'(out), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_level", 8'(fifo_level), 8'd0);
    chk("rst_overflow", 8'(overflow), 8'd0);
    model_reset();
    rst_n = 1'b1;
    forward_en = 1'b1;

    // Directed table: single bit N=4, then swapped bit N=3
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].d, tv[i].s, int'(tv[i].pw), 1'b1, tv[i].sw);
      cycle();
      chk($sformatf("vec%0d_out", i), 8'(out), 8'(tv[i].eo));
      chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(tv[i].eb));
      chk($sformatf("vec%0d_level", i), 8'(fifo_level), 8'(tv[i].el));
    end

    // 1,0,1 spaced 8 cycles apart at N=4: back-to-back, level never above 1
    max_lvl = 0;
    for (int k = 0; k < 3; k++) begin
      drive((k != 1), 1'b1, 4, 1'b1, 1'b0);
      cycle();
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      in_clk = 1'b0;
      for (int j = 0; j < 7; j++) begin
        cycle();
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
    end
    idle(12);
    chk("seq101_max_level", 8'(max_lvl), 8'd1);

    // Clamp: pw=0 gives 2-cycle halves
    drive(1'b0, 1'b1, 0, 1'b1, 1'b0);
    cycle();
    in_clk = 1'b0;
    cycle(); chk("clamp0_e1", 8'(out), 8'd1);
    cycle(); chk("clamp0_e2", 8'(out), 8'd1);
    cycle(); chk("clamp0_e3", 8'(out), 8'd0);
    idle(3);
    drive(1'b1, 1'b1, 1, 1'b1, 1'b0);
    cycle();
    idle(6);

    // Pulse width change 4 -> 6 mid-bit
    drive(1'b1, 1'b1, 4, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 4, 1'b1, 1'b0);
    cycle();
    in_clk = 1'b0;
    in_pulsewidth = PW'(6);
    idle(24);

    // Overflow: 6 consecutive strobes at N=5
    for (int k = 0; k < 6; k++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 5, 1'b1, 1'b0);
      cycle();
    end
    chk("ovf_set", 8'(overflow), 8'd1);
    chk("ovf_level", 8'(fifo_level), 8'd4);
    idle(1);
`ifdef FWD_OVERFLOW_STICKY_EN
    chk("ovf_hold", 8'(overflow), 8'd1);
`else
    chk("ovf_pulse", 8'(overflow), 8'd0);
`endif
    idle(4);
    drive(1'b1, 1'b1, 5, 1'b1, 1'b0);
    cycle();
    chk("full_pop_level", 8'(fifo_level), 8'd4);
`ifdef FWD_OVERFLOW_STICKY_EN
    chk("full_pop_ovf", 8'(overflow), 8'd1);
`else
    chk("full_pop_ovf", 8'(overflow), 8'd0);
`endif
    in_clk = 1'b0;
    forward_en = 1'b0;
    cycle();
    chk("ovf_clear", 8'(overflow), 8'd0);
    idle(60);

    // forward_en=0: strobes ignored
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 3, 1'b0, 1'b0);
      cycle();
    end
    chk("fwd_dis_level", 8'(fifo_level), 8'd0);
    chk("fwd_dis_out", 8'(out), 8'd0);
    idle(2);

    // Async reset in FIRST_HALF with a bit still queued
    drive(1'b0, 1'b1, 6, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 6, 1'b1, 1'b0);
    cycle();
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 8'(out), 8'd0);
    chk("arst_level", 8'(fifo_level), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
            ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
      cycle();
    end
    idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
